// File: rtl/gmii_tx_framer_if.sv
// FIFO read port and GMII transmit pins of the transmit framer.
// master = framer side, slave = FIFO/PHY side.
interface gmii_tx_framer_if;
  logic       rd_en;
  logic [8:0] rd_data;
  logic       rd_empty;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic [7:0] gmii_txd;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_empty,
    output gmii_tx_en,
    output gmii_tx_er,
    output gmii_txd
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_empty,
    input  gmii_tx_en,
    input  gmii_tx_er,
    input  gmii_txd
  );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: drains a 9-bit non-FWFT FIFO and emits preamble, SFD,
// payload, optional CRC-32 FCS and an inter-frame gap; FIFO underrun aborts with tx_er.
module gmii_tx_framer #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter bit          FCS_APPEND = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  gmii_tx_framer_if.master bus,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      underrun_cnt
);

  localparam logic [15:0] PreLast = 16'd6;
  localparam logic [15:0] FcsLast = 16'd3;
  localparam logic [15:0] IfgLast = 16'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLook,
    StPre,
    StSfd,
    StData,
    StFcs,
    StDrop,
    StIfg
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] crc_q, crc_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic [7:0]  txd_q, txd_d;

  logic        rd_en;
  logic        word_flag;
  logic [7:0]  word_byte;
  logic [31:0] crc_inv;

  assign word_flag = bus.rd_data[8];
  assign word_byte = bus.rd_data[7:0];
  assign crc_inv   = ~crc_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (rd_en) state_d = StLook;
      end
      StLook: begin
        if (word_flag) begin
          state_d = StPre;
        end else if (rd_en) begin
          state_d = StLook;
        end else begin
          state_d = StIdle;
        end
      end
      StPre: begin
        if (cnt_q == PreLast) state_d = StSfd;
      end
      StSfd: state_d = StData;
      StData: begin
        if (!pend_q) begin
          state_d = StDrop;
        end else if (!word_flag) begin
          state_d = FCS_APPEND ? StFcs : StIfg;
        end
      end
      StFcs: begin
        if (cnt_q == FcsLast) state_d = StIfg;
      end
      StDrop: begin
        if (pend_q && !word_flag) state_d = StIfg;
      end
      StIfg: begin
        if (cnt_q == IfgLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO read strobe; never issued while empty or held in reset
  always_comb begin
    rd_en = 1'b0;
    case (state_q)
      StIdle: rd_en = !bus.rd_empty;
      StLook: rd_en = !word_flag && !bus.rd_empty;
      StSfd:  rd_en = !bus.rd_empty;
      StData: rd_en = pend_q && word_flag && !bus.rd_empty;
      StDrop: rd_en = !(pend_q && !word_flag) && !bus.rd_empty;
      default: rd_en = 1'b0;
    endcase
    if (sys_rst) rd_en = 1'b0;
  end

  // Datapath and pin next-state
  always_comb begin
    hold_d         = hold_q;
    crc_d          = crc_q;
    pend_d         = pend_q;
    err_d          = 1'b0;
    cnt_d          = cnt_q;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    tx_en_d        = 1'b0;
    tx_er_d        = 1'b0;
    txd_d          = 8'h00;
    case (state_q)
      StLook: begin
        if (word_flag) begin
          hold_d = word_byte;
          crc_d  = 32'hFFFF_FFFF;
          cnt_d  = 16'd0;
        end
      end
      StPre: begin
        tx_en_d = 1'b1;
        txd_d   = 8'h55;
        cnt_d   = cnt_q + 16'd1;
      end
      StSfd: begin
        tx_en_d = 1'b1;
        txd_d   = 8'hD5;
        pend_d  = rd_en;
      end
      StData: begin
        tx_en_d = 1'b1;
        txd_d   = hold_q;
        crc_d   = crc_byte(crc_q, hold_q);
        if (pend_q) begin
          if (word_flag) begin
            hold_d = word_byte;
            pend_d = rd_en;
          end else begin
            pend_d = 1'b0;
            cnt_d  = 16'd0;
            if (!FCS_APPEND) frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else begin
          // Starved: the error marker goes out in the first DROP cycle
          err_d          = 1'b1;
          pend_d         = 1'b0;
          underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
      end
      StFcs: begin
        tx_en_d = 1'b1;
        txd_d   = crc_inv[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d   = cnt_q + 16'd1;
        if (cnt_q == FcsLast) begin
          cnt_d       = 16'd0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      StDrop: begin
        if (err_q) begin
          tx_en_d = 1'b1;
          tx_er_d = 1'b1;
        end
        pend_d = rd_en;
        if (pend_q && !word_flag) cnt_d = 16'd0;
      end
      StIfg: begin
        cnt_d = cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_q         <= 8'h00;
      crc_q          <= 32'h0000_0000;
      pend_q         <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= 16'd0;
      frame_cnt_q    <= 16'd0;
      underrun_cnt_q <= 16'd0;
      tx_en_q        <= 1'b0;
      tx_er_q        <= 1'b0;
      txd_q          <= 8'h00;
    end else begin
      hold_q         <= hold_d;
      crc_q          <= crc_d;
      pend_q         <= pend_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
      tx_en_q        <= tx_en_d;
      tx_er_q        <= tx_er_d;
      txd_q          <= txd_d;
    end
  end

  assign bus.rd_en      = rd_en;
  assign bus.gmii_tx_en = tx_en_q;
  assign bus.gmii_tx_er = tx_er_q;
  assign bus.gmii_txd   = txd_q;
  assign frame_cnt      = frame_cnt_q;
  assign underrun_cnt   = underrun_cnt_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: FIFO model, pin capture monitor and a frame-level
// reference model (preamble/SFD/payload/CRC-32) for directed and random frames.
module tb_gmii_tx_framer;

  logic        sys_clk;
  logic        sys_rst;
  logic [15:0] frame_cnt;
  logic [15:0] underrun_cnt;

  gmii_tx_framer_if bus ();

  gmii_tx_framer #(
    .IFG_CYCLES(12),
    .FCS_APPEND(1'b1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .bus         (bus),
    .frame_cnt   (frame_cnt),
    .underrun_cnt(underrun_cnt)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // FIFO model: written by the stimulus, popped on rd_en, data valid next cycle
  logic [8:0] fifo_mem [0:4095];
  int pushed = 0;
  int popped = 0;
  int cyc    = 0;
  int viol   = 0;
  int rise_n = 0;
  int rise_mem [0:1023];
  logic rd_prev = 1'b0;

  assign bus.rd_empty = (pushed == popped);

  always @(posedge sys_clk) begin
    if (bus.rd_en && bus.rd_empty) viol++;
    if (bus.rd_en && !rd_prev) begin
      rise_mem[rise_n] = cyc;
      rise_n++;
    end
    rd_prev = bus.rd_en;
    if (bus.rd_en) begin
      bus.rd_data <= fifo_mem[popped];
      popped      <= popped + 1;
    end
    cyc++;
  end

  // Pin monitor: captures every tx_en burst as one frame
  logic [7:0] cap_mem [0:8191];
  int cap_wr = 0;
  int fr_n   = 0;
  int fr_len [0:255];
  int fr_erc [0:255];
  int fr_erl [0:255];
  int fr_gap [0:255];
  int fr_rise [0:255];
  int fr_pay [0:255];
  int cur_len = 0;
  int cur_er  = 0;
  int cur_erl = 0;
  int low_cnt = 0;
  logic en_prev = 1'b0;

  always @(negedge sys_clk) begin
    if (bus.gmii_tx_en) begin
      if (!en_prev) begin
        fr_gap[fr_n]  = low_cnt;
        fr_rise[fr_n] = cyc;
        cur_len       = 0;
        cur_er        = 0;
      end
      cap_mem[cap_wr] = bus.gmii_txd;
      cap_wr++;
      cur_len++;
      if (bus.gmii_tx_er) cur_er++;
      cur_erl = int'(bus.gmii_tx_er);
      if (cur_len == 9) fr_pay[fr_n] = cyc;
    end else begin
      if (en_prev) begin
        fr_len[fr_n] = cur_len;
        fr_erc[fr_n] = cur_er;
        fr_erl[fr_n] = cur_erl;
        fr_n++;
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
    end
    en_prev = bus.gmii_tx_en;
  end

  // Reference model and bookkeeping used by the stimulus
  logic [7:0] pay_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  logic [7:0] got_q [$];
  int cap_rd = 0;
  int fr_rd  = 0;
  int got_erc, got_erl, got_gap, got_rise, got_pay;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [8:0] w);
    fifo_mem[pushed] = w;
    pushed++;
  endtask

  task automatic push_payload(input int n, input bit term);
    logic [7:0] b;
    pay_q.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      pay_q.push_back(b);
      push_word({1'b1, b});
    end
    if (term) push_word({1'b0, 8'($urandom)});
  endtask

  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, pay_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_exp(input int n_sent, input bit fcs, input bit underrun);
    logic [31:0] fcs_word;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n_sent; i++) exp_q.push_back(pay_q[i]);
    if (fcs) begin
      fcs_word = ~ref_crc(n_sent);
      for (int k = 0; k < 4; k++) exp_q.push_back(fcs_word[8*k +: 8]);
    end
    if (underrun) exp_q.push_back(8'h00);
  endtask

  task automatic take_frame();
    got_q.delete();
    got_erc = -1;
    got_erl = -1;
    got_gap = -1;
    got_rise = -1;
    got_pay = -1;
    if (fr_rd < fr_n) begin
      for (int i = 0; i < fr_len[fr_rd]; i++) begin
        got_q.push_back(cap_mem[cap_rd]);
        cap_rd++;
      end
      got_erc  = fr_erc[fr_rd];
      got_erl  = fr_erl[fr_rd];
      got_gap  = fr_gap[fr_rd];
      got_rise = fr_rise[fr_rd];
      got_pay  = fr_pay[fr_rd];
      fr_rd++;
    end
  endtask

  task automatic wait_frame(input string tag);
    int k = 0;
    while (fr_n <= fr_rd && k < 400) begin
      @(negedge sys_clk);
      k++;
    end
    check({tag, "_seen"}, 32'(fr_n > fr_rd), 32'd1);
    take_frame();
  endtask

  task automatic cmp_frame(input string tag);
    int mism = 0;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got_q.size()) mism++;
      else if (got_q[i] !== exp_q[i]) mism++;
    end
    check({tag, "_bytes"}, 32'(mism), 32'd0);
    check({tag, "_er"}, 32'(got_erc), 32'd0);
  endtask

  logic [7:0] kfcs [0:20];
  int busy;
  int ri;
  int k;
  int exp_frames;
  int len;

  initial begin
    kfcs = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
             8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
    exp_frames = 0;

    // Reset and idle
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_tx_en", 32'(bus.gmii_tx_en), 32'd0);
    check("rst_tx_er", 32'(bus.gmii_tx_er), 32'd0);
    check("rst_txd", 32'(bus.gmii_txd), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    busy = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (bus.rd_en || bus.gmii_tx_en || bus.gmii_tx_er) busy++;
    end
    check("idle_activity", 32'(busy), 32'd0);
    check("idle_frame_cnt", 32'(frame_cnt), 32'd0);
    check("idle_underrun_cnt", 32'(underrun_cnt), 32'd0);

    // Known FCS: "123456789" and latency from the first read
    ri = rise_n;
    for (int i = 0; i < 9; i++) push_word({1'b1, 8'(8'h31 + i)});
    push_word(9'h000);
    wait_frame("fcs");
    check("fcs_len", 32'(got_q.size()), 32'd21);
    for (int i = 0; i < 21; i++) begin
      check("fcs_byte", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(kfcs[i]));
    end
    exp_frames++;
    check("fcs_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("lat_tx_en", 32'(got_rise - rise_mem[ri]), 32'd3);
    check("lat_payload", 32'(got_pay - rise_mem[ri]), 32'd11);

    // Leading garbage words are discarded
    @(negedge sys_clk);
    for (int i = 0; i < 3; i++) push_word({1'b0, 8'($urandom)});
    push_payload(20, 1'b1);
    build_exp(20, 1'b1, 1'b0);
    wait_frame("garbage");
    cmp_frame("garbage");
    exp_frames++;
    check("garbage_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Back-to-back 64-byte frames
    @(negedge sys_clk);
    push_payload(64, 1'b1);
    build_exp(64, 1'b1, 1'b0);
    exp_a = exp_q;
    push_payload(64, 1'b1);
    build_exp(64, 1'b1, 1'b0);
    exp_b = exp_q;
    wait_frame("b2b_a");
    exp_q = exp_a;
    cmp_frame("b2b_a");
    wait_frame("b2b_b");
    exp_q = exp_b;
    cmp_frame("b2b_b");
    check("b2b_gap", 32'(got_gap), 32'd14);
    exp_frames += 2;
    check("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Underrun: 10 bytes, starve, then 5 bytes and terminator that must be dropped
    @(negedge sys_clk);
    push_payload(10, 1'b0);
    build_exp(10, 1'b0, 1'b1);
    k = 0;
    while (pushed != popped && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    check("ur_drained", 32'(pushed == popped), 32'd1);
    repeat (5) @(negedge sys_clk);
    for (int i = 0; i < 5; i++) push_word({1'b1, 8'($urandom)});
    push_word(9'h000);
    wait_frame("ur");
    check("ur_len", 32'(got_q.size()), 32'(exp_q.size()));
    k = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got_q.size()) k++;
      else if (got_q[i] !== exp_q[i]) k++;
    end
    check("ur_bytes", 32'(k), 32'd0);
    check("ur_er_count", 32'(got_erc), 32'd1);
    check("ur_er_last", 32'(got_erl), 32'd1);
    repeat (30) @(negedge sys_clk);
    check("ur_underrun_cnt", 32'(underrun_cnt), 32'd1);
    check("ur_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    push_payload(15, 1'b1);
    build_exp(15, 1'b1, 1'b0);
    wait_frame("ur_next");
    cmp_frame("ur_next");
    exp_frames++;
    check("ur_next_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Random frames with random leading garbage; first one is a 1-byte payload
    for (int f = 0; f < 6; f++) begin
      @(negedge sys_clk);
      len = (f == 0) ? 1 : int'($urandom_range(2, 48));
      k = int'($urandom_range(0, 2));
      for (int g = 0; g < k; g++) push_word({1'b0, 8'($urandom)});
      push_payload(len, 1'b1);
      build_exp(len, 1'b1, 1'b0);
      wait_frame("rnd");
      cmp_frame("rnd");
      exp_frames++;
      check("rnd_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    end
    check("rnd_underrun_cnt", 32'(underrun_cnt), 32'd1);

    // Reset in the middle of a payload
    @(negedge sys_clk);
    push_payload(30, 1'b1);
    k = 0;
    while (!bus.gmii_tx_en && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    check("mid_started", 32'(bus.gmii_tx_en), 32'd1);
    repeat (14) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("mid_rst_tx_en", 32'(bus.gmii_tx_en), 32'd0);
    check("mid_rst_tx_er", 32'(bus.gmii_tx_er), 32'd0);
    check("mid_rst_txd", 32'(bus.gmii_txd), 32'd0);
    check("mid_rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("rd_en_while_empty", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
